// File: rtl/mem_pkg.sv
// mem_pkg: default widths, issue FSM states and the request entry type
// shared by the memory request queue.
package mem_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 4;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: generic circular-buffer FIFO; exposes the head and the entry
// behind it so the consumer can chain issues without a bubble.
module mem_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [W-1:0]             rdata_nxt_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o      = count_q == CW'(DEPTH);
    assign empty_o     = count_q == '0;
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;
    assign rd_nxt      = rd_ptr_q + AW'(1);
    assign rdata_o     = mem_q[rd_ptr_q];
    assign rdata_nxt_o = mem_q[rd_nxt];
    assign count_o     = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: buffers memory requests and issues them on a valid/ready port,
// returning tagged read data. Define MEM_REQ_QUEUE_STATS_EN for handshake counters.
module mem_req_queue #(
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int TAG_WIDTH  = mem_pkg::TAG_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_wr_i,
    input  logic [ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [TAG_WIDTH-1:0]     req_tag_i,
    output logic                     mem_valid_o,
    output logic                     mem_wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    output logic                     rsp_valid_o,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
    output logic [TAG_WIDTH-1:0]     rsp_tag_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef MEM_REQ_QUEUE_STATS_EN
    ,
    output logic [31:0]              wr_cnt_o,
    output logic [31:0]              rd_cnt_o,
    output logic                     ovf_o
`endif
);
    import mem_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    req_t                  push_data, head, nxt, src;
    logic                  full, empty, hs, load;
    logic [CW-1:0]         count;
    state_t                state_q, state_d;
    logic                  mem_valid_q, mem_valid_d, mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [TAG_WIDTH-1:0]  mem_tag_q, mem_tag_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

    assign push_data = '{wr: req_wr_i, addr: req_addr_i, wdata: req_wdata_i, tag: req_tag_i};

    mem_req_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (req_valid_i & req_ready_o),
        .wdata_i     (push_data),
        .pop_i       (hs),
        .rdata_o     (head),
        .rdata_nxt_o (nxt),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    // The issuing entry stays in the FIFO until its handshake; chaining takes the one behind it.
    assign hs   = mem_valid_q & mem_ready_i;
    assign load = (state_q == IDLE) ? !empty : hs && count > CW'(1);
    assign src  = (state_q == IDLE) ? head : nxt;

    always_comb begin
        state_d     = load ? ISSUE : hs ? IDLE : state_q;
        mem_valid_d = load | (mem_valid_q & ~hs);
        mem_wr_d    = load ? src.wr : mem_wr_q;
        mem_addr_d  = load ? src.addr : mem_addr_q;
        mem_wdata_d = load ? src.wdata : mem_wdata_q;
        mem_tag_d   = load ? src.tag : mem_tag_q;
        rsp_valid_d = hs & ~mem_wr_q;
        rsp_rdata_d = rsp_valid_d ? mem_rdata_i : rsp_rdata_q;
        rsp_tag_d   = rsp_valid_d ? mem_tag_q : rsp_tag_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_tag_q   <= mem_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign req_ready_o    = ~full;
    assign mem_valid_o    = mem_valid_q;
    assign mem_wr_rd_en_o = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_tag_o      = rsp_tag_q;
    assign count_o        = count;

`ifdef MEM_REQ_QUEUE_STATS_EN
    logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q + 32'(hs & mem_wr_q);
        rd_cnt_d = rd_cnt_q + 32'(hs & ~mem_wr_q);
        ovf_d    = ovf_q | (req_valid_i & full);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;
    assign ovf_o    = ovf_q;
`endif

endmodule
